maxpool_fp32: RTL and testbench

- Streaming fp32 max-pool reducer placed directly downstream of the relu activation stage.
- Consumes a stream of IEEE-754 single-precision activations and emits one maximum per non-overlapping window of WINDOW samples, with the in-window index of that maximum.
- Valid/ready handshakes on both sides; a single registered output stage provides backpressure to the activation pipeline.

---
 rtl/maxpool_fp32.sv | 156 +++++++++++++++
 tb/tb_maxpool_fp32.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_fp32.sv
// ---------------------------------------------------------------------------
// maxpool_fp32
//
// Streaming fp32 max-pool reducer. Consumes IEEE-754 single-precision
// activations and emits one maximum per non-overlapping window of WINDOW
// samples, along with the in-window index of that maximum. A window can be
// closed early with in_last, which produces a result flagged as partial.
// A single registered output stage holds the result under backpressure.
//
// Optional feature (macro MAXPOOL_FP32_NAN_PROP_EN):
//   defined   - any NaN in a window forces the result to the canonical
//               quiet NaN 32'h7fc00000, indexed at the first NaN sample.
//   undefined - NaNs are ordered by bit pattern like any other value.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     input sample valid
//   in_ready     block can accept a sample this cycle
//   in_data      fp32 activation
//   in_last      sample closes the current window early
//   out_valid    pooled result valid
//   out_ready    downstream accepts result
//   out_data     fp32 window maximum
//   out_idx      position of the maximum within its window
//   out_partial  result came from a window closed before WINDOW samples
// ---------------------------------------------------------------------------
module maxpool_fp32 #(
    parameter int WINDOW = 4,
    parameter int IDX_W  = $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_partial
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

    // Sign-magnitude "strictly greater than" for fp32 bit patterns.
    function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
        logic res;
        if (a[31] != b[31]) begin
            // +0 and -0 compare equal; otherwise the positive operand wins.
            res = ((a[30:0] | b[30:0]) == 31'd0) ? 1'b0 : !a[31];
        end else if (!a[31]) begin
            res = a[30:0] > b[30:0];
        end else begin
            res = a[30:0] < b[30:0];
        end
        return res;
    endfunction

    logic [IDX_W-1:0] count;
    logic [31:0]      acc_max;
    logic [IDX_W-1:0] acc_idx;

    logic             accept;
    logic             close;
    logic             take;
    logic [31:0]      new_max;
    logic [IDX_W-1:0] new_idx;
    logic [31:0]      res_data;
    logic [IDX_W-1:0] res_idx;

`ifdef MAXPOOL_FP32_NAN_PROP_EN
    logic             nan_flag;
    logic [IDX_W-1:0] nan_idx;
    logic             in_nan;
`endif

    // Stall input only while a result is held unaccepted.
    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign close    = accept & ((count == LAST_IDX) | in_last);

    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        take     = 1'b0;
        new_max  = acc_max;
        new_idx  = acc_idx;
        res_data = 32'd0;
        res_idx  = '0;
        // First sample of a window always seeds the accumulator; ties keep
        // the earlier sample because gt() is strict.
        take = (count == '0) || gt(in_data, acc_max);
        if (take) begin
            new_max = in_data;
            new_idx = count;
        end
        res_data = new_max;
        res_idx  = new_idx;
`ifdef MAXPOOL_FP32_NAN_PROP_EN
        in_nan = (in_data[30:23] == 8'hff) && (in_data[22:0] != 23'd0);
        if (nan_flag) begin
            res_data = 32'h7fc0_0000;
            res_idx  = nan_idx;
        end else if (in_nan) begin
            res_data = 32'h7fc0_0000;
            res_idx  = count;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            acc_max     <= 32'd0;
            acc_idx     <= '0;
            out_valid   <= 1'b0;
            out_data    <= 32'd0;
            out_idx     <= '0;
            out_partial <= 1'b0;
`ifdef MAXPOOL_FP32_NAN_PROP_EN
            nan_flag    <= 1'b0;
            nan_idx     <= '0;
`endif
        end else begin
            if (accept) begin
                acc_max <= new_max;
                acc_idx <= new_idx;
                count   <= close ? '0 : count + IDX_W'(1);
`ifdef MAXPOOL_FP32_NAN_PROP_EN
                if (close) begin
                    nan_flag <= 1'b0;
                end else if (in_nan && !nan_flag) begin
                    nan_flag <= 1'b1;
                    nan_idx  <= count;
                end
`endif
            end

            // A close can only happen when the output slot is empty or being
            // drained this cycle, so loading here never overwrites a held result.
            if (close) begin
                out_valid   <= 1'b1;
                out_data    <= res_data;
                out_idx     <= res_idx;
                out_partial <= in_last && (count != LAST_IDX);
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_fp32.sv
// ---------------------------------------------------------------------------
// tb_maxpool_fp32
//
// Self-checking bench for maxpool_fp32 (WINDOW=4). Table-driven windows with
// a scoreboard queue of expected results, plus hand-written sequences for
// output backpressure and mid-window reset.
// ---------------------------------------------------------------------------
module tb_maxpool_fp32;

    localparam int WINDOW = 4;
    localparam int IDX_W  = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_partial;

    maxpool_fp32 #(.WINDOW(WINDOW), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_partial (out_partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      data;
        logic [IDX_W-1:0] idx;
        logic             partial;
    } exp_t;

    typedef struct {
        logic [3:0][31:0] d;        // d[0] is the first sample
        int               n;        // samples in window; n<4 closes with in_last
        logic             last_fin; // assert in_last on the 4th sample too
        exp_t             e;
    } vec_t;

    exp_t q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d,
                                input int n, input logic lf,
                                input logic [31:0] ed, input logic [IDX_W-1:0] ei,
                                input logic ep);
        vec_t v;
        v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = d;
        v.n = n; v.last_fin = lf;
        v.e.data = ed; v.e.idx = ei; v.e.partial = ep;
        return v;
    endfunction

    // Scoreboard: every output transfer pops and compares one expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_output: got %h idx %0d, none expected", out_data, out_idx);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_idx", 32'(out_idx), 32'(e.idx));
                    check("out_partial", 32'(out_partial), 32'(e.partial));
                end
            end
        end
    end

    // Present one sample and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] d, input logic last);
        int w;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'hdead_beef;
    endtask

    task automatic run_vec(input vec_t v);
        q.push_back(v.e);
        for (int k = 0; k < v.n; k++) begin
            logic lb;
            lb = (k == v.n - 1) && (v.n < WINDOW || v.last_fin);
            send(v.d[k], lb);
            if (k < v.n - 1) check("no_early_valid", 32'(out_valid), 32'd0);
            else             check("latency_1", 32'(out_valid), 32'd1);
        end
    endtask

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        vecs[0]  = mk(32'h3f800000, 32'h40000000, 32'h3f000000, 32'h00000000, 4, 1'b0, 32'h40000000, 2'd1, 1'b0);
        vecs[1]  = mk(32'hbf800000, 32'hc0000000, 32'hbf000000, 32'hc0400000, 4, 1'b0, 32'hbf000000, 2'd2, 1'b0);
        vecs[2]  = mk(32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000, 4, 1'b0, 32'h80000000, 2'd0, 1'b0);
        vecs[3]  = mk(32'h3f800000, 32'h40400000, 32'h0,        32'h0,        2, 1'b1, 32'h40400000, 2'd1, 1'b1);
        vecs[4]  = mk(32'h00800000, 32'h7f800000, 32'h3f800000, 32'h7f7fffff, 4, 1'b0, 32'h7f800000, 2'd1, 1'b0);
        vecs[5]  = mk(32'hff800000, 32'h80000001, 32'hff7fffff, 32'hbf800000, 4, 1'b1, 32'h80000001, 2'd1, 1'b0);
        vecs[6]  = mk(32'h3f800000, 32'h0,        32'h0,        32'h0,        1, 1'b1, 32'h3f800000, 2'd0, 1'b1);
        vecs[7]  = mk(32'h40000000, 32'h40000000, 32'h3f800000, 32'h40000000, 4, 1'b0, 32'h40000000, 2'd0, 1'b0);
        vecs[8]  = mk(32'hc0000000, 32'h00000001, 32'h80000000, 32'h00000000, 4, 1'b0, 32'h00000001, 2'd1, 1'b0);
`ifdef MAXPOOL_FP32_NAN_PROP_EN
        vecs[9]  = mk(32'h3f800000, 32'h7f800001, 32'h40000000, 32'h00000000, 4, 1'b0, 32'h7fc00000, 2'd1, 1'b0);
        vecs[10] = mk(32'hff800001, 32'hff800000, 32'hbf800000, 32'hc0000000, 4, 1'b0, 32'h7fc00000, 2'd0, 1'b0);
`else
        vecs[9]  = mk(32'h3f800000, 32'h7f800001, 32'h40000000, 32'h00000000, 4, 1'b0, 32'h7f800001, 2'd1, 1'b0);
        vecs[10] = mk(32'hff800001, 32'hff800000, 32'hbf800000, 32'hc0000000, 4, 1'b0, 32'hbf800000, 2'd2, 1'b0);
`endif

        // Reset state.
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_partial", 32'(out_partial), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Table-driven windows, downstream always ready.
        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Backpressure: drain pending result, then hold the next one.
        @(posedge clk); #1;
        out_ready = 1'b0;
        q.push_back('{data: 32'h40a00000, idx: 2'd1, partial: 1'b0});
        send(32'h3f800000, 1'b0);
        send(32'h40a00000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h3f000000, 1'b0);
        check("bp_latency", 32'(out_valid), 32'd1);
        // First sample of the next window waits while the result is held.
        in_valid = 1'b1;
        in_data  = 32'h41000000;
        in_last  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", out_data, 32'h40a00000);
            check("bp_out_idx", 32'(out_idx), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        q.push_back('{data: 32'h41000000, idx: 2'd0, partial: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_drained", 32'(out_valid), 32'd0);
        send(32'h40e00000, 1'b0);
        send(32'hc0000000, 1'b0);
        send(32'h41000000, 1'b0);
        check("bp_next_latency", 32'(out_valid), 32'd1);

        // Mid-window reset: two samples accepted, then discarded.
        @(posedge clk); #1;
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_out_idx", 32'(out_idx), 32'd0);
        check("midrst_out_partial", 32'(out_partial), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(mk(32'h3f000000, 32'h3f800000, 32'h3e800000, 32'h3f400000, 4, 1'b0, 32'h3f800000, 2'd1, 1'b0));

        // Let the scoreboard drain (bounded).
        for (int w = 0; w < 20 && q.size() != 0; w++) @(posedge clk);
        @(posedge clk); #1;
        check("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
